// File: rtl/banked_register_file.sv
// Register file with mode-banked upper registers, write-through bypass and a
// per-entry reservation scoreboard for hazard detection between ID and WB.
module banked_register_file #(
  parameter int unsigned ADDRESS_LEN  = 4,
  parameter int unsigned SIZE         = 15,
  parameter int unsigned DATA_LEN     = 32,
  parameter int unsigned NUM_READ     = 3,
  parameter int unsigned BANKS        = 2,
  parameter int unsigned BANK_LEN     = 1,
  parameter int unsigned BANKED_FIRST = 13,
  parameter int unsigned CNT_LEN      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BANK_LEN-1:0]           rd_bank,
  input  logic [NUM_READ*ADDRESS_LEN-1:0] rd_addr,
  output logic [NUM_READ*DATA_LEN-1:0]  rd_data,
  output logic [NUM_READ-1:0]           rd_busy,
  input  logic                          writeBackEn,
  input  logic [ADDRESS_LEN-1:0]        Dest_wb,
  input  logic [BANK_LEN-1:0]           wb_bank,
  input  logic [DATA_LEN-1:0]           Result_wb,
  input  logic                          rsv_en,
  input  logic [ADDRESS_LEN-1:0]        rsv_addr,
  input  logic                          flush,
  output logic                          rsv_full,
  output logic                          sb_err
);

  localparam int unsigned PHYS  = SIZE + (BANKS - 1) * (SIZE - BANKED_FIRST);
  localparam int unsigned IDX_W = (PHYS > 1) ? $clog2(PHYS) : 1;
  localparam logic [CNT_LEN-1:0] CNT_MAX = '1;
  localparam logic [CNT_LEN-1:0] CNT_ONE = CNT_LEN'(1);

  // Banked copies live after the shared entries; bank 0 and out-of-range banks
  // use the base entries. Unstored addresses map to 0 and are gated by callers.
  function automatic logic [IDX_W-1:0] map_idx(input logic [ADDRESS_LEN-1:0] a,
                                               input logic [BANK_LEN-1:0] b);
    int unsigned ai, bi, r;
    ai = 32'(a);
    bi = 32'(b);
    if (ai >= SIZE) r = 0;
    else if (ai < BANKED_FIRST || bi == 0 || bi >= BANKS) r = ai;
    else r = SIZE + (bi - 1) * (SIZE - BANKED_FIRST) + (ai - BANKED_FIRST);
    return IDX_W'(r);
  endfunction

  function automatic logic [DATA_LEN-1:0] reset_val(input int unsigned i);
    if (i < SIZE || SIZE <= BANKED_FIRST) return DATA_LEN'(i);
    return DATA_LEN'(BANKED_FIRST + (i - SIZE) % (SIZE - BANKED_FIRST));
  endfunction

  logic [DATA_LEN-1:0] regs_q [PHYS];
  logic [CNT_LEN-1:0]  cnt_q  [PHYS];
  logic                sb_err_q;

  logic             wb_hit, rsv_hit, same_hit, sb_set;
  logic [IDX_W-1:0] wb_idx, rsv_idx;

  always_comb begin
    wb_hit   = writeBackEn && (32'(Dest_wb) < SIZE);
    rsv_hit  = rsv_en && (32'(rsv_addr) < SIZE);
    wb_idx   = map_idx(Dest_wb, wb_bank);
    rsv_idx  = map_idx(rsv_addr, rd_bank);
    same_hit = wb_hit && rsv_hit && (wb_idx == rsv_idx);
    sb_set   = !flush && !same_hit &&
               ((rsv_hit && cnt_q[rsv_idx] == CNT_MAX) || (wb_hit && cnt_q[wb_idx] == '0));
    rsv_full = (32'(rsv_addr) < SIZE) && (cnt_q[rsv_idx] == CNT_MAX);
  end

  always_comb begin
    logic [ADDRESS_LEN-1:0] a;
    logic [IDX_W-1:0]       idx;
    logic [CNT_LEN-1:0]     cnt;
    logic                   valid, byp;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      a     = rd_addr[k*ADDRESS_LEN +: ADDRESS_LEN];
      idx   = map_idx(a, rd_bank);
      cnt   = cnt_q[idx];
      valid = 32'(a) < SIZE;
      byp   = valid && wb_hit && (wb_idx == idx);
      if (byp) rd_data[k*DATA_LEN +: DATA_LEN] = Result_wb;
      else if (valid) rd_data[k*DATA_LEN +: DATA_LEN] = regs_q[idx];
      // The last outstanding writer is completing now and its data is bypassed.
      rd_busy[k] = valid && (cnt != '0) && !(byp && cnt == CNT_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHYS; i++) begin
        regs_q[i] <= reset_val(i);
        cnt_q[i]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (wb_hit) regs_q[wb_idx] <= Result_wb;
      if (flush) begin
        for (int i = 0; i < PHYS; i++) cnt_q[i] <= '0;
      end else if (!same_hit) begin
        if (rsv_hit && cnt_q[rsv_idx] != CNT_MAX) cnt_q[rsv_idx] <= cnt_q[rsv_idx] + CNT_ONE;
        if (wb_hit && cnt_q[wb_idx] != '0) cnt_q[wb_idx] <= cnt_q[wb_idx] - CNT_ONE;
      end
      if (sb_set) sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_banked_register_file.sv
// Scoreboard bench for banked_register_file: expectations are queued as stimulus
// is driven and drained against the DUT outputs between clock edges.
module tb_banked_register_file;
  localparam int AL = 4;
  localparam int DL = 32;
  localparam int NR = 3;
  localparam int D0 = 0, D1 = 1, D2 = 2, B0 = 3, B1 = 4, B2 = 5, FULL = 6, ERR = 7;

  logic           clk = 1'b0;
  logic           rst;
  logic [0:0]     rd_bank;
  logic [NR*AL-1:0] rd_addr;
  logic [NR*DL-1:0] rd_data;
  logic [NR-1:0]  rd_busy;
  logic           writeBackEn;
  logic [AL-1:0]  Dest_wb;
  logic [0:0]     wb_bank;
  logic [DL-1:0]  Result_wb;
  logic           rsv_en;
  logic [AL-1:0]  rsv_addr;
  logic           flush;
  logic           rsv_full;
  logic           sb_err;

  banked_register_file dut (
    .clk        (clk),
    .rst        (rst),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .writeBackEn(writeBackEn),
    .Dest_wb    (Dest_wb),
    .wb_bank    (wb_bank),
    .Result_wb  (Result_wb),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .flush      (flush),
    .rsv_full   (rsv_full),
    .sb_err     (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check_eq(input logic [95:0] tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    if (sel <= D2) return rd_data[sel*DL +: DL];
    if (sel <= B2) return {31'b0, rd_busy[sel-B0]};
    if (sel == FULL) return {31'b0, rsv_full};
    return {31'b0, sb_err};
  endfunction

  task automatic push_exp(input logic [95:0] tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic set_rd(input logic [AL-1:0] a0, input logic [AL-1:0] a1, input logic [AL-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rd_bank = '0; writeBackEn = 0; Dest_wb = '0; wb_bank = '0; Result_wb = '0;
    rsv_en = 0; rsv_addr = '0; flush = 0;
    set_rd(0, 7, 14);
    #1 rst = 1'b0;
    #1;
    push_exp("rst_d0", D0, 0); push_exp("rst_d1", D1, 7); push_exp("rst_d2", D2, 14);
    push_exp("rst_b0", B0, 0); push_exp("rst_b1", B1, 0); push_exp("rst_b2", B2, 0);
    push_exp("rst_err", ERR, 0); push_exp("rst_full", FULL, 0);
    drain();
    set_rd(15, 7, 14); rsv_addr = 15;
    #1;
    push_exp("r15_data", D0, 0); push_exp("r15_busy", B0, 0); push_exp("r15_full", FULL, 0);
    drain();
    #9 rst = 1'b1;
    cycle();

    // Reserve R3, R13 (bank 1) and R5 so the later writes release cleanly
    set_rd(3, 13, 5); rsv_en = 1; rsv_addr = 3; rd_bank = 0;
    #1; push_exp("r3_pre", B0, 0); drain();
    cycle(); push_exp("r3_rsv", B0, 1); drain();
    rsv_addr = 13; rd_bank = 1;
    #1; push_exp("r13_pre", B1, 0); drain();
    cycle(); push_exp("r13_rsv", B1, 1); drain();
    rsv_addr = 5;
    cycle(); rsv_en = 0; rd_bank = 0;
    #1; push_exp("r5_shared", B2, 1); push_exp("r13_b0", B1, 0); drain();

    writeBackEn = 1; Dest_wb = 3; wb_bank = 0; Result_wb = 32'hDEADBEEF;
    #1; push_exp("byp_r3", D0, 32'hDEADBEEF); push_exp("byp_busy", B0, 0); drain();
    cycle(); writeBackEn = 0;
    #1; push_exp("r3_held", D0, 32'hDEADBEEF); push_exp("r3_free", B0, 0);
    push_exp("err_clean", ERR, 0); drain();

    writeBackEn = 1; Dest_wb = 13; wb_bank = 1; Result_wb = 32'h1111;
    #1; push_exp("nobyp_bank", D1, 13); drain();
    cycle(); writeBackEn = 0;
    #1; push_exp("r13_b0", D1, 13); drain();
    rd_bank = 1;
    #1; push_exp("r13_b1", D1, 32'h1111); push_exp("r13_free", B1, 0); drain();

    rd_bank = 0; writeBackEn = 1; Dest_wb = 5; wb_bank = 1; Result_wb = 32'h5555;
    cycle(); writeBackEn = 0;
    #1; push_exp("r5_b0", D2, 32'h5555); push_exp("r5_free", B2, 0);
    push_exp("err_clean2", ERR, 0); drain();

    // Saturate R2
    set_rd(2, 15, 14); rsv_en = 1; rsv_addr = 2;
    repeat (2) cycle();
    push_exp("r2_cnt2", FULL, 0); push_exp("r2_busy", B0, 1); drain();
    cycle();
    push_exp("r2_full", FULL, 1); push_exp("r2_noerr", ERR, 0); push_exp("r15_busy", B1, 0);
    drain();
    cycle();
    push_exp("r2_sat", FULL, 1); push_exp("sat_err", ERR, 1); drain();
    rsv_en = 0; flush = 1;
    cycle(); flush = 0;
    #1; push_exp("flush_busy", B0, 0); push_exp("flush_full", FULL, 0);
    push_exp("err_sticky", ERR, 1); drain();

    // Asynchronous reset with pending reservations and a write in flight
    set_rd(3, 6, 2); rsv_en = 1; rsv_addr = 6;
    cycle(); rsv_addr = 2;
    cycle();
    push_exp("r6_rsv", B1, 1); push_exp("r2_rsv", B2, 1); drain();
    writeBackEn = 1; Dest_wb = 3; wb_bank = 0; Result_wb = 32'h99; rsv_addr = 6;
    #2 rst = 1'b0; writeBackEn = 0; rsv_en = 0;
    #1; push_exp("ar_r3", D0, 3); push_exp("ar_b6", B1, 0); push_exp("ar_b2", B2, 0);
    push_exp("ar_err", ERR, 0); drain();
    rd_bank = 1; set_rd(3, 13, 2);
    #1; push_exp("ar_r13b1", D1, 13); push_exp("ar_r3b1", D0, 3); drain();
    #1 rst = 1'b1; rd_bank = 0;
    cycle();

    // Reserve R4 twice, release three times
    set_rd(4, 15, 0); rsv_en = 1; rsv_addr = 4;
    repeat (2) cycle();
    rsv_en = 0; writeBackEn = 1; Dest_wb = 4; wb_bank = 0; Result_wb = 32'h4444;
    #1; push_exp("r4_cnt2", B0, 1); push_exp("r4_err0", ERR, 0); drain();
    cycle(); Result_wb = 32'h4545;
    #1; push_exp("r4_last", B0, 0); push_exp("r4_byp", D0, 32'h4545); drain();
    cycle(); writeBackEn = 0;
    #1; push_exp("r4_zero", B0, 0); push_exp("r4_err1", ERR, 0);
    push_exp("r4_data", D0, 32'h4545); drain();
    writeBackEn = 1; Result_wb = 32'h4646;
    cycle(); writeBackEn = 0;
    #1; push_exp("under_err", ERR, 1); push_exp("under_busy", B0, 0);
    push_exp("under_data", D0, 32'h4646); drain();

    // Writes to R15 are dropped and must not alias onto R0
    writeBackEn = 1; Dest_wb = 15; Result_wb = 32'hFFFF;
    #1; push_exp("w15_nobyp", D1, 0); push_exp("w15_r0", D2, 0); drain();
    cycle(); writeBackEn = 0;
    #1; push_exp("w15_r0_post", D2, 0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/banked_register_file.md
Name: banked_register_file

Overview:
- Next-generation ARM register file. Replaces the single-bank, two-read-port file.
- Adds a configurable number of combinational read ports and mode-banked upper registers (R13/R14 per processor mode).
- Adds write-through bypass and a per-register reservation scoreboard, so the hazard unit can stall on pending writebacks.
- Sits between the ID stage (reads, reservations) and the WB stage (write, release).

Parameters:
- ADDRESS_LEN, 4, architectural register address width.
- SIZE, 15, number of architectural registers (R0..R14); addresses >= SIZE (e.g. R15/PC) are not stored.
- DATA_LEN, 32, register width.
- NUM_READ, 3, number of read ports.
- BANKS, 2, number of register banks; bank 0 = user mode.
- BANK_LEN, 1, bank select width; must satisfy 2^BANK_LEN >= BANKS.
- BANKED_FIRST, 13, first banked address; addresses BANKED_FIRST..SIZE-1 have one copy per bank.
- CNT_LEN, 2, scoreboard counter width per register.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- rd_bank  input  BANK_LEN  bank used for all read ports and for reservations.
- rd_addr  input  NUM_READ*ADDRESS_LEN  read addresses; port k occupies bits [k*ADDRESS_LEN +: ADDRESS_LEN].
- rd_data  output  NUM_READ*DATA_LEN  read data, packed the same way as rd_addr.
- rd_busy  output  NUM_READ  port k's register has an outstanding reservation.
- writeBackEn  input  1  write and release strobe.
- Dest_wb  input  ADDRESS_LEN  write address.
- wb_bank  input  BANK_LEN  bank captured at issue for the write.
- Result_wb  input  DATA_LEN  write data.
- rsv_en  input  1  reserve rsv_addr in rd_bank.
- rsv_addr  input  ADDRESS_LEN  register to reserve.
- flush  input  1  clear all reservations.
- rsv_full  output  1  reservation counter of rsv_addr is saturated.
- sb_err  output  1  sticky scoreboard error flag.

Behaviour:
- Physical mapping:
  - Address a < BANKED_FIRST maps to shared entry a.
  - BANKED_FIRST <= a < SIZE maps to that bank's private copy.
  - Physical depth = SIZE + (BANKS-1)*(SIZE-BANKED_FIRST).
  - A bank value >= BANKS is treated as bank 0.
- Reset (rst low, asynchronous):
  - Every physical entry of architectural address a resets to a, zero-extended. This applies in every bank.
  - All scoreboard counters reset to 0; sb_err resets to 0.
  - Outputs are combinational from this state: rd_busy=0, rsv_full=0, and rd_data[k] = rd_addr[k] when rd_addr[k] < SIZE.
  - Reset asserted mid-operation discards any pending write and all reservations.
- Reads: zero latency, combinational.
  - rd_data[k] = 0 when rd_addr[k] >= SIZE.
  - Bypass: when writeBackEn=1, Dest_wb < SIZE, and the write maps to the same physical entry as port k, rd_data[k] = Result_wb in that same cycle.
  - A write to the same address in a different bank does not bypass when the address is banked.
- Write:
  - At posedge with writeBackEn=1 and Dest_wb < SIZE, the mapped entry takes Result_wb.
  - Dest_wb >= SIZE writes nothing.
- Scoreboard: one CNT_LEN-bit counter per physical entry.
  - Reserve: at posedge with rsv_en=1, rsv_addr < SIZE, and the mapped counter below max, the counter increments.
  - Saturation: reserving a saturated counter leaves it unchanged and sets sb_err.
  - Release: writeBackEn=1 with Dest_wb < SIZE decrements the counter mapped via wb_bank. Releasing a counter already at 0 leaves it at 0 and sets sb_err.
  - Reserve and release of the same counter in the same cycle: net unchanged.
  - flush=1 clears all counters at posedge and overrides any same-cycle reserve or release. The register write itself still occurs.
  - sb_err is sticky; only reset clears it.
- rd_busy[k]:
  - Set when the mapped counter != 0.
  - Exception: if the counter == 1 and a release to that entry occurs this cycle, rd_busy[k] = 0, because the data is bypassed.
  - Always 0 when rd_addr[k] >= SIZE.
- rsv_full is combinational: mapped counter of rsv_addr == 2^CNT_LEN-1. It is 0 when rsv_addr >= SIZE.

Test Plan:
- Reset, then read ports {0,7,14} in bank 0 -> rd_data = {0,7,14}, rd_busy=0, sb_err=0. Read address 15 -> data 0.
- Write R3=0xDEADBEEF with port 0 reading R3 in the same cycle -> rd_data[0]=0xDEADBEEF immediately. After the posedge, R3 still reads 0xDEADBEEF.
- Write R13=0x1111 in bank 1, then read R13 in bank 0 -> 13; in bank 1 -> 0x1111. Write R5 via bank 1, read R5 via bank 0 -> new value (shared).
- Reserve R4 twice, then release once -> rd_busy stays 1. Second release with R4 on a read port -> rd_busy=0 in the release cycle. A further release -> counter stays 0, sb_err=1.
- Reserve R2 three times (CNT_LEN=2) -> rsv_full=1. A fourth reserve -> count stays 3, sb_err=1. flush -> rd_busy for R2 = 0 next cycle.
- Pulse rst low mid-sequence with pending reservations and writeBackEn=1 -> all counters 0, R3 reads 3, sb_err=0, asynchronously without waiting for a clock edge.
